// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for a five-stage in-order pipeline.
// It resolves memory freezes, EX-stage redirects, load-use bubbles and ID-stage jal flushes.
// A data-memory wait that exceeds MEM_TIMEOUT cycles parks the block in a sticky error state.
// Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cnt/flush_cnt performance counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [1:0] RegReadD,
   input  logic [4:0] RdE,
   input  logic       MemToRegE,
   input  logic [2:0] RegWriteE,
   input  logic       BranchE,
   input  logic       JalrE,
   input  logic       JalD,
   input  logic       mem_req,
   input  logic       mem_ack,
   output logic       en_PC,
   output logic       en_IFID,
   output logic       clr_IFID,
   output logic       en_IDEX,
   output logic       clr_IDEX,
   output logic       en_EXMEM,
   output logic       clr_EXMEM,
   output logic       en_MEMWB,
   output logic       clr_MEMWB,
   output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      ERR     = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_C = MEM_TIMEOUT[7:0];

   state_t     state_q, state_d;
   logic [7:0] wcnt_q, wcnt_d;
   logic       mem_err_q, mem_err_d;
   logic       load_use;
   logic       redirect;
   // Enable vector order: {PC, IFID, IDEX, EXMEM, MEMWB}; clear vector order: {IFID, IDEX, EXMEM, MEMWB}.
   logic [4:0] run_en, en_c;
   logic [3:0] run_clr, clr_c;

   // Hazard detection: a load in EX whose destination is read by the instruction in ID.
   always_comb begin
      load_use = MemToRegE && (RegWriteE != 3'd0) && (RdE != 5'd0) &&
                 ((RegReadD[0] && (Rs1D == RdE)) || (RegReadD[1] && (Rs2D == RdE)));
      redirect = BranchE || JalrE;
   end

   // Normal-flow control when no memory freeze applies: redirect beats load-use beats jal.
   always_comb begin
      run_en  = 5'b11111;
      run_clr = 4'b0000;
      if (redirect) begin
         run_clr = 4'b1100;
      end else if (load_use) begin
         run_en  = 5'b00111;
         run_clr = 4'b0100;
      end else if (JalD) begin
         run_clr = 4'b1000;
      end
   end

   // Next-state, wait-counter and per-state output selection.
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      mem_err_d = mem_err_q;
      en_c      = run_en;
      clr_c     = run_clr;
      case (state_q)
         RUN: begin
            if (mem_req && !mem_ack) begin
               en_c    = 5'b00000;
               clr_c   = 4'b0000;
               state_d = MEMWAIT;
               wcnt_d  = 8'd1;
            end
         end
         MEMWAIT: begin
            if (mem_ack) begin
               state_d = RUN;
               wcnt_d  = 8'd0;
            end else begin
               en_c  = 5'b00000;
               clr_c = 4'b0000;
               if (wcnt_q == TIMEOUT_C) begin
                  state_d   = ERR;
                  mem_err_d = 1'b1;
               end else if (wcnt_q != 8'hFF) begin
                  wcnt_d = wcnt_q + 8'd1;
               end
            end
         end
         ERR: begin
            en_c  = 5'b00000;
            clr_c = 4'b0000;
         end
         default: begin
            state_d = RUN;
            wcnt_d  = 8'd0;
         end
      endcase
   end

   // State registers; reset returns to RUN with the counter and error flag cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         wcnt_q    <= 8'd0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   // Drive outputs; reset forces every stage held and cleared without waiting for a clock.
   always_comb begin
      if (!rst_n) begin
         {en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB} = 5'b00000;
         {clr_IFID, clr_IDEX, clr_EXMEM, clr_MEMWB}    = 4'b1111;
         mem_err                                       = 1'b0;
      end else begin
         {en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB} = en_c;
         {clr_IFID, clr_IDEX, clr_EXMEM, clr_MEMWB}    = clr_c;
         mem_err                                       = mem_err_q;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   // Count cycles with the PC held and cycles with IF/ID flushed; both wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_q + {31'd0, ~en_PC};
         flush_cnt_q <= flush_cnt_q + {31'd0, clr_IFID};
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MEM_TIMEOUT overridden to 4).
module tb_pipeline_hazard_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] Rs1D, Rs2D, RdE;
   logic [1:0] RegReadD;
   logic       MemToRegE;
   logic [2:0] RegWriteE;
   logic       BranchE, JalrE, JalD;
   logic       mem_req, mem_ack;
   logic       en_PC, en_IFID, clr_IFID, en_IDEX, clr_IDEX;
   logic       en_EXMEM, clr_EXMEM, en_MEMWB, clr_MEMWB;
   logic       mem_err;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Rs1D      (Rs1D),
      .Rs2D      (Rs2D),
      .RegReadD  (RegReadD),
      .RdE       (RdE),
      .MemToRegE (MemToRegE),
      .RegWriteE (RegWriteE),
      .BranchE   (BranchE),
      .JalrE     (JalrE),
      .JalD      (JalD),
      .mem_req   (mem_req),
      .mem_ack   (mem_ack),
      .en_PC     (en_PC),
      .en_IFID   (en_IFID),
      .clr_IFID  (clr_IFID),
      .en_IDEX   (en_IDEX),
      .clr_IDEX  (clr_IDEX),
      .en_EXMEM  (en_EXMEM),
      .clr_EXMEM (clr_EXMEM),
      .en_MEMWB  (en_MEMWB),
      .clr_MEMWB (clr_MEMWB),
      .mem_err   (mem_err)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   // {PC, IFID, IDEX, EXMEM, MEMWB} and {IFID, IDEX, EXMEM, MEMWB}
   function automatic logic [4:0] en_v();
      return {en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB};
   endfunction

   function automatic logic [3:0] clr_v();
      return {clr_IFID, clr_IDEX, clr_EXMEM, clr_MEMWB};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [4:0] en_e, input logic [3:0] clr_e,
                          input logic err_e);
      check_eq({tag, ".en"},  {27'd0, en_v()},  {27'd0, en_e});
      check_eq({tag, ".clr"}, {28'd0, clr_v()}, {28'd0, clr_e});
      check_eq({tag, ".err"}, {31'd0, mem_err}, {31'd0, err_e});
   endtask

   // Advance to just after the next rising edge, where inputs are changed.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sample point in the middle of the cycle.
   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_in();
      Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0; RegReadD = 2'b00;
      MemToRegE = 1'b0; RegWriteE = 3'd0;
      BranchE = 1'b0; JalrE = 1'b0; JalD = 1'b0;
      mem_req = 1'b0; mem_ack = 1'b0;
   endtask

   task automatic load_use_in();
      MemToRegE = 1'b1; RegWriteE = 3'd1; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd0; RegReadD = 2'b01;
   endtask

   initial begin
      idle_in();
      rst_n = 1'b0;
      mid();
      chk_out("reset", 5'b00000, 4'b1111, 1'b0);
      tick();
      rst_n = 1'b1;
      mid();
      chk_out("idle", 5'b11111, 4'b0000, 1'b0);

      // Load-use hazards and near misses
      tick(); load_use_in();
      mid(); chk_out("lu_rs1", 5'b00111, 4'b0100, 1'b0);
      tick(); RdE = 5'd0; Rs1D = 5'd0;
      mid(); chk_out("lu_rd0", 5'b11111, 4'b0000, 1'b0);
      tick(); load_use_in(); RegReadD = 2'b10; Rs1D = 5'd0; Rs2D = 5'd5;
      mid(); chk_out("lu_rs2", 5'b00111, 4'b0100, 1'b0);
      tick(); RegReadD = 2'b01;
      mid(); chk_out("lu_rs2_notread", 5'b11111, 4'b0000, 1'b0);
      tick(); load_use_in(); RegWriteE = 3'd0;
      mid(); chk_out("lu_nowrite", 5'b11111, 4'b0000, 1'b0);
      tick(); load_use_in(); RegWriteE = 3'd4; MemToRegE = 1'b0;
      mid(); chk_out("lu_notload", 5'b11111, 4'b0000, 1'b0);

      // Redirect and jal priority
      tick(); load_use_in(); BranchE = 1'b1;
      mid(); chk_out("branch_over_lu", 5'b11111, 4'b1100, 1'b0);
      tick(); BranchE = 1'b0; JalrE = 1'b1; JalD = 1'b1;
      mid(); chk_out("jalr_over_jal", 5'b11111, 4'b1100, 1'b0);
      tick(); JalrE = 1'b0;
      mid(); chk_out("lu_over_jal", 5'b00111, 4'b0100, 1'b0);
      tick(); idle_in(); JalD = 1'b1;
      mid(); chk_out("jal_only", 5'b11111, 4'b1000, 1'b0);

      // Memory wait released by ack after 3 frozen cycles
      tick(); idle_in(); mem_req = 1'b1; BranchE = 1'b1;
      mid(); chk_out("wait_c1_freeze_over_br", 5'b00000, 4'b0000, 1'b0);
      tick(); BranchE = 1'b0;
      mid(); chk_out("wait_c2", 5'b00000, 4'b0000, 1'b0);
      tick();
      mid(); chk_out("wait_c3", 5'b00000, 4'b0000, 1'b0);
      tick(); mem_ack = 1'b1; JalD = 1'b1;
      mid(); chk_out("wait_ack", 5'b11111, 4'b1000, 1'b0);
      tick(); idle_in();
      mid(); chk_out("wait_back_run", 5'b11111, 4'b0000, 1'b0);

      // Asynchronous reset in the middle of a wait
      tick(); mem_req = 1'b1;
      tick();
      mid(); chk_out("areset_pre", 5'b00000, 4'b0000, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk_out("areset_now", 5'b00000, 4'b1111, 1'b0);
      tick(); idle_in();
      tick(); rst_n = 1'b1;
      mid(); chk_out("areset_run", 5'b11111, 4'b0000, 1'b0);

      // Timeout with MEM_TIMEOUT=4: ERR after the fifth waiting cycle
      tick(); mem_req = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         mid(); chk_out($sformatf("tmo_wait%0d", i), 5'b00000, 4'b0000, 1'b0);
         tick();
      end
      mid(); chk_out("tmo_err", 5'b00000, 4'b0000, 1'b1);
      tick(); mem_ack = 1'b1;
      mid(); chk_out("tmo_ack_ignored", 5'b00000, 4'b0000, 1'b1);
      tick(); idle_in();
      mid(); chk_out("tmo_sticky", 5'b00000, 4'b0000, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk_out("tmo_reset", 5'b00000, 4'b1111, 1'b0);
      tick(); rst_n = 1'b1;
      mid(); chk_out("tmo_after_reset", 5'b11111, 4'b0000, 1'b0);

`ifdef HAZARD_PERF_CNT_EN
      // Perf counters: two load-use stalls and three jal flushes
      tick(); rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      mid();
      check_eq("perf_stall_reset", stall_cnt, 32'd0);
      check_eq("perf_flush_reset", flush_cnt, 32'd0);
      tick(); load_use_in();
      tick(); idle_in();
      tick(); load_use_in();
      tick(); idle_in(); JalD = 1'b1;
      tick();
      tick();
      tick(); idle_in();
      mid();
      check_eq("perf_stall", stall_cnt, 32'd2);
      check_eq("perf_flush", flush_cnt, 32'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
